// File: rtl/tdd_frame_timer.sv
// tdd_frame_timer
// Sample-domain frame timer for the AXI2S stream movers. Counts samples
// within a frame, flags the first sample of each frame, counts completed
// frames and opens the TX/RX gates inside their programmed windows. Frame
// length comes from the register block and can be stretched or shortened
// for exactly one frame through a signed one-shot adjustment.

module tdd_frame_timer #(
  parameter int CW      = 24,
  parameter int MIN_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          sample_en,
  input  logic          tddmode,
  input  logic [CW-1:0] frame_len,
  input  logic [CW-1:0] frame_adj,
  input  logic          adj_wr,
  input  logic [CW-1:0] tstart,
  input  logic [CW-1:0] tend,
  input  logic [CW-1:0] rstart,
  input  logic [CW-1:0] rend,
  output logic [CW-1:0] frame_cnt,
  output logic [31:0]   frame_num,
  output logic          frame_start,
  output logic          tx_en,
  output logic          rx_en,
  output logic          adj_pending
);

  // IDLE covers both "run low" and "run high but no sample seen yet";
  // RUN means a frame is in progress and the counter is meaningful.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MIN_L = CW'(MIN_LEN);

  logic [0:0]    state;
  logic [CW-1:0] cur_len;
  logic [CW-1:0] adj_val;

  logic [CW+1:0] plain_ext;
  logic [CW+1:0] adj_ext;
  logic [CW-1:0] plain_len;
  logic [CW-1:0] latch_len;
  logic [CW-1:0] last_idx;
  logic          at_end;
  logic          do_latch;
  logic [CW-1:0] next_cnt;
  logic          tx_next;
  logic          rx_next;

  // The sum is treated as signed in CW+2 bits: bit CW+1 set means the
  // adjustment drove the length negative, bit CW set means it overflowed.
  function automatic logic [CW-1:0] clamp_len(input logic [CW+1:0] v);
    logic [CW-1:0] r;
    if (v[CW+1])
      r = MIN_L;
    else if (v[CW])
      r = '1;
    else if (v[CW-1:0] < MIN_L)
      r = MIN_L;
    else
      r = v[CW-1:0];
    return r;
  endfunction

  // A start greater than the end describes a window that wraps through
  // the frame boundary.
  function automatic logic in_window(input logic [CW-1:0] c,
                                     input logic [CW-1:0] s,
                                     input logic [CW-1:0] e);
    logic hit;
    if (s <= e)
      hit = (c >= s) && (c <= e);
    else
      hit = (c >= s) || (c <= e);
    return hit;
  endfunction

  // Next-state decode: length to latch, whether this sample closes a frame,
  // the counter value it produces and the gates evaluated on that value.
  always_comb begin
    plain_ext = {2'b00, frame_len};
    adj_ext   = {{2{adj_val[CW-1]}}, adj_val};
    plain_len = clamp_len(plain_ext);
    latch_len = adj_pending ? clamp_len(plain_ext + adj_ext) : plain_len;
    last_idx  = cur_len - ONE;
    at_end    = (state == ST_RUN) && (frame_cnt == last_idx);
    do_latch  = run && sample_en && ((state == ST_IDLE) || at_end);
    next_cnt  = ((state == ST_RUN) && !at_end) ? frame_cnt + ONE : '0;
    tx_next   = tddmode ? in_window(next_cnt, tstart, tend) : 1'b1;
    rx_next   = tddmode ? in_window(next_cnt, rstart, rend) : 1'b1;
  end

  // Frame state, counters, gates and the one-shot adjustment register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      frame_num   <= '0;
      frame_start <= 1'b0;
      tx_en       <= 1'b0;
      rx_en       <= 1'b0;
      adj_pending <= 1'b0;
      adj_val     <= '0;
      cur_len     <= plain_len;
    end else begin
      frame_start <= 1'b0;
      if (adj_wr) begin
        adj_pending <= 1'b1;
        adj_val     <= frame_adj;
      end else if (do_latch) begin
        adj_pending <= 1'b0;
      end
      if (!run) begin
        state     <= ST_IDLE;
        frame_cnt <= '0;
        frame_num <= '0;
        tx_en     <= 1'b0;
        rx_en     <= 1'b0;
      end else if (sample_en) begin
        state       <= ST_RUN;
        frame_cnt   <= next_cnt;
        frame_start <= do_latch;
        tx_en       <= tx_next;
        rx_en       <= rx_next;
        if (do_latch)
          cur_len <= latch_len;
        if (at_end)
          frame_num <= frame_num + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdd_frame_timer.sv
// Directed testbench for tdd_frame_timer: reset, FDD defaults, TDD windows
// (plain and wrapping), one-shot length adjustment, adjustment written on a
// boundary, sparse sample strobes, stop and mid-frame reset.

module tb_tdd_frame_timer;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          sample_en;
  logic          tddmode;
  logic [CW-1:0] frame_len;
  logic [CW-1:0] frame_adj;
  logic          adj_wr;
  logic [CW-1:0] tstart;
  logic [CW-1:0] tend;
  logic [CW-1:0] rstart;
  logic [CW-1:0] rend;
  logic [CW-1:0] frame_cnt;
  logic [31:0]   frame_num;
  logic          frame_start;
  logic          tx_en;
  logic          rx_en;
  logic          adj_pending;

  int assertions = 0;
  int failures   = 0;

  logic [CW-1:0] e_cnt;
  logic [31:0]   e_num;
  logic          e_st;
  logic          e_tx;
  logic          e_rx;
  logic          e_pend;

  always #5 clk = ~clk;

  tdd_frame_timer #(.CW(CW), .MIN_LEN(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .sample_en   (sample_en),
    .tddmode     (tddmode),
    .frame_len   (frame_len),
    .frame_adj   (frame_adj),
    .adj_wr      (adj_wr),
    .tstart      (tstart),
    .tend        (tend),
    .rstart      (rstart),
    .rend        (rend),
    .frame_cnt   (frame_cnt),
    .frame_num   (frame_num),
    .frame_start (frame_start),
    .tx_en       (tx_en),
    .rx_en       (rx_en),
    .adj_pending (adj_pending)
  );

  // Advance one clock and settle just after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; sample_en = 1'b0; tddmode = 1'b0; adj_wr = 1'b0;
    frame_len = 24'd1920; frame_adj = '0;
    tstart = '0; tend = 24'd1919; rstart = '0; rend = 24'd1919;
    tick();
    tick();
    e_cnt = '0; e_st = 0; e_num = '0; e_tx = 0; e_rx = 0; e_pend = 0;
    assertions++;
    if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
        {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
      failures++;
      $display("[TB] FAIL reset got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b pend=%0b exp all 0",
               frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fdd_defaults();
    run = 1'b1; sample_en = 1'b1;
    for (int k = 0; k <= 3 * 1920; k++) begin
      tick();
      e_cnt = CW'(k % 1920); e_st = (k % 1920 == 0); e_num = 32'(k / 1920);
      e_tx = 1; e_rx = 1; e_pend = 0;
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL fdd k=%0d got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b pend=%0b exp cnt=%0d st=%0b num=%0d tx=1 rx=1 pend=0",
                 k, frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending, e_cnt, e_st, e_num);
      end
    end
    run = 1'b0;
    tick();
    e_cnt = '0; e_st = 0; e_num = '0; e_tx = 0; e_rx = 0; e_pend = 0;
    assertions++;
    if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
        {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
      failures++;
      $display("[TB] FAIL fdd_stop got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b exp all 0",
               frame_cnt, frame_start, frame_num, tx_en, rx_en);
    end
  endtask

  task automatic test_tdd_windows();
    int c;
    frame_len = 24'd10; tddmode = 1'b1;
    tstart = 24'd2; tend = 24'd4; rstart = 24'd6; rend = 24'd8;
    run = 1'b1; sample_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      c = k % 10;
      e_cnt = CW'(c); e_st = (c == 0); e_num = 32'(k / 10);
      e_tx = (c >= 2 && c <= 4); e_rx = (c >= 6 && c <= 8); e_pend = 0;
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL tdd_win k=%0d got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b exp cnt=%0d st=%0b num=%0d tx=%0b rx=%0b",
                 k, frame_cnt, frame_start, frame_num, tx_en, rx_en, e_cnt, e_st, e_num, e_tx, e_rx);
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_wrap_window();
    int c;
    tstart = 24'd8; tend = 24'd1;
    run = 1'b1; sample_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      c = k % 10;
      e_cnt = CW'(c); e_st = (c == 0); e_num = 32'(k / 10);
      e_tx = (c >= 8 || c <= 1); e_rx = (c >= 6 && c <= 8); e_pend = 0;
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL wrap_win k=%0d got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b exp cnt=%0d st=%0b num=%0d tx=%0b rx=%0b",
                 k, frame_cnt, frame_start, frame_num, tx_en, rx_en, e_cnt, e_st, e_num, e_tx, e_rx);
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_adjust();
    // +3 written after cnt 5: frames are 10, 13, then 10 again.
    tddmode = 1'b0; run = 1'b1; sample_en = 1'b1; frame_adj = 24'd3;
    for (int k = 0; k <= 40; k++) begin
      adj_wr = (k == 6);
      tick();
      if (k < 10) begin e_cnt = CW'(k); e_num = 32'd0; end
      else if (k < 23) begin e_cnt = CW'(k - 10); e_num = 32'd1; end
      else begin e_cnt = CW'((k - 23) % 10); e_num = 32'(2 + (k - 23) / 10); end
      e_st = (e_cnt == '0); e_tx = 1; e_rx = 1; e_pend = (k >= 6 && k <= 9);
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL adj_plus k=%0d got cnt=%0d st=%0b num=%0d pend=%0b exp cnt=%0d st=%0b num=%0d pend=%0b",
                 k, frame_cnt, frame_start, frame_num, adj_pending, e_cnt, e_st, e_num, e_pend);
      end
    end
    adj_wr = 1'b0;
    run = 1'b0;
    tick();
    // -20 clamps to the 2-sample floor for exactly one frame.
    frame_adj = 24'hFFFFEC;
    run = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      adj_wr = (k == 3);
      tick();
      if (k < 10) begin e_cnt = CW'(k); e_num = 32'd0; end
      else if (k < 12) begin e_cnt = CW'(k - 10); e_num = 32'd1; end
      else begin e_cnt = CW'((k - 12) % 10); e_num = 32'(2 + (k - 12) / 10); end
      e_st = (e_cnt == '0); e_tx = 1; e_rx = 1; e_pend = (k >= 3 && k <= 9);
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL adj_minus k=%0d got cnt=%0d st=%0b num=%0d pend=%0b exp cnt=%0d st=%0b num=%0d pend=%0b",
                 k, frame_cnt, frame_start, frame_num, adj_pending, e_cnt, e_st, e_num, e_pend);
      end
    end
    adj_wr = 1'b0;
    run = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    // adj_wr lands on the boundary sample: that frame stays 10, the next is 13.
    run = 1'b1; sample_en = 1'b1; frame_adj = 24'd3;
    for (int k = 0; k <= 45; k++) begin
      adj_wr = (k == 10);
      tick();
      if (k < 20) begin e_cnt = CW'(k % 10); e_num = 32'(k / 10); end
      else if (k < 33) begin e_cnt = CW'(k - 20); e_num = 32'd2; end
      else begin e_cnt = CW'((k - 33) % 10); e_num = 32'(3 + (k - 33) / 10); end
      e_st = (e_cnt == '0); e_tx = 1; e_rx = 1; e_pend = (k >= 10 && k <= 19);
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL adj_boundary k=%0d got cnt=%0d st=%0b num=%0d pend=%0b exp cnt=%0d st=%0b num=%0d pend=%0b",
                 k, frame_cnt, frame_start, frame_num, adj_pending, e_cnt, e_st, e_num, e_pend);
      end
    end
    adj_wr = 1'b0;
    run = 1'b0;
    tick();
  endtask

  task automatic test_sparse_stop_reset();
    int c;
    tddmode = 1'b1; tstart = 24'd2; tend = 24'd4; rstart = 24'd6; rend = 24'd8;
    frame_adj = 24'd5; run = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      sample_en = (j % 3 == 0);
      adj_wr = (j == 7);
      tick();
      c = j / 3;
      e_cnt = CW'(c); e_st = (j == 0); e_num = '0;
      e_tx = (c >= 2 && c <= 4); e_rx = (c >= 6 && c <= 8); e_pend = (j >= 7);
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL sparse j=%0d got cnt=%0d st=%0b tx=%0b rx=%0b pend=%0b exp cnt=%0d st=%0b tx=%0b rx=%0b pend=%0b",
                 j, frame_cnt, frame_start, tx_en, rx_en, adj_pending, e_cnt, e_st, e_tx, e_rx, e_pend);
      end
    end
    adj_wr = 1'b0;
    run = 1'b0; sample_en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      e_cnt = '0; e_st = 0; e_num = '0; e_tx = 0; e_rx = 0; e_pend = 1;
      assertions++;
      if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
          {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
        failures++;
        $display("[TB] FAIL stop j=%0d got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b pend=%0b exp 0 0 0 0 0 1",
                 j, frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending);
      end
    end
    run = 1'b1;
    for (int j = 0; j <= 21; j++) begin
      sample_en = (j % 3 == 0);
      tick();
      e_cnt = CW'(j / 3);
      assertions++;
      if (frame_cnt !== e_cnt) begin
        failures++;
        $display("[TB] FAIL restart j=%0d got cnt=%0d exp cnt=%0d", j, frame_cnt, e_cnt);
      end
    end
    rst = 1'b1; sample_en = 1'b1;
    tick();
    e_cnt = '0; e_st = 0; e_num = '0; e_tx = 0; e_rx = 0; e_pend = 0;
    assertions++;
    if ({frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending} !==
        {e_cnt, e_st, e_num, e_tx, e_rx, e_pend}) begin
      failures++;
      $display("[TB] FAIL mid_reset got cnt=%0d st=%0b num=%0d tx=%0b rx=%0b pend=%0b exp all 0",
               frame_cnt, frame_start, frame_num, tx_en, rx_en, adj_pending);
    end
    rst = 1'b0; run = 1'b0; sample_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fdd_defaults();
    test_tdd_windows();
    test_wrap_window();
    test_adjust();
    test_back_to_back();
    test_sparse_stop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
